// File: rtl/serial_xact_ctrl.sv
// ---------------------------------------------------------------------------
// serial_xact_ctrl
//
// Sequences single register-access transactions into the synchronous serial
// engine. A request accepted on the valid/ready handshake becomes one TX frame
// {write, addr, data}, sent MSB first. For a write the data field holds the
// write data; for a read it is zero. The block drives the engine's chip select,
// start and stall inputs. On reads it captures the RX word, and it reports
// completion with a one-cycle response strobe.
//
// Optional build macro: XACT_TIMEOUT_EN
//   When defined, a watchdog limits the time spent waiting on the engine in
//   SEND and RECV to TIMEOUT cycles. An expired transaction is aborted and
//   answered with resp_err=1. Without it resp_err is tied to 0.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req_valid/ready   request handshake (no queueing, one at a time)
//   req_write         1 = write, 0 = read
//   req_addr          register address (ADDR_W)
//   req_wdata         write data (DATA_W), ignored on reads
//   resp_valid        one-cycle completion pulse
//   resp_rdata        read data (zero after a write), held until next read
//   resp_err          timeout flag, qualified by resp_valid
//   eng_csb           engine chip select, active low
//   eng_tx            frame to engine (FRAME_W)
//   eng_tx_start      engine start request
//   eng_tx_busy       engine TX stall
//   eng_rx_busy       engine RX stall
//   eng_tx_done       engine last-TX-bit level
//   eng_rx_done       engine last-RX-bit level
//   eng_rx            engine received word (DATA_W)
// ---------------------------------------------------------------------------
module serial_xact_ctrl #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int FRAME_W  = 1 + ADDR_W + DATA_W,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               resp_valid,
    output logic [DATA_W-1:0]  resp_rdata,
    output logic               resp_err,
    output logic               eng_csb,
    output logic [FRAME_W-1:0] eng_tx,
    output logic               eng_tx_start,
    output logic               eng_tx_busy,
    output logic               eng_rx_busy,
    input  logic               eng_tx_done,
    input  logic               eng_rx_done,
    input  logic [DATA_W-1:0]  eng_rx
);

    // Parameter sanity: the frame must match the engine and both chip-select
    // guard times need at least one cycle.
    if (FRAME_W != 1 + ADDR_W + DATA_W) begin : g_bad_frame_w
        $error("serial_xact_ctrl: FRAME_W must equal 1+ADDR_W+DATA_W");
    end
    if (CS_SETUP < 1 || CS_HOLD < 1 || TIMEOUT < 1) begin : g_bad_timing
        $error("serial_xact_ctrl: CS_SETUP, CS_HOLD and TIMEOUT must be >= 1");
    end

    localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_W  = $clog2(CS_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SEND  = 3'd2,
        RECV  = 3'd3,
        HOLD  = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                write_reg;
    logic                tx_done_prev_reg;
    logic                rx_done_prev_reg;
    logic                req_ready_reg;
    logic                resp_valid_reg;
    logic [DATA_W-1:0]   resp_rdata_reg;
    logic                eng_csb_reg;
    logic [FRAME_W-1:0]  eng_tx_reg;
    logic                eng_tx_start_reg;
    logic                eng_tx_busy_reg;
    logic                eng_rx_busy_reg;

    // Data field of the frame: write data on writes, zero on reads.
    logic [DATA_W-1:0]   wdata_field;
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_wdata_field
        assign wdata_field[gi] = req_wdata[gi] & req_write;
    end

    logic [FRAME_W-1:0]  frame_next;
    assign frame_next = {req_write, req_addr, wdata_field};

    logic accept;
    logic tx_fall;
    logic rx_fall;
    logic timeout_hit;

    assign accept  = (state_reg == IDLE) && req_valid && req_ready_reg;
    // The engine's done levels are only trusted on their falling edge; the
    // RX word is not stable before eng_rx_done drops.
    assign tx_fall = tx_done_prev_reg & ~eng_tx_done;
    assign rx_fall = rx_done_prev_reg & ~eng_rx_done;

`ifdef XACT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            resp_err_reg;

    // A normal completion in the same cycle as expiry wins over the abort.
    assign timeout_hit = (((state_reg == SEND) && !tx_fall) ||
                          ((state_reg == RECV) && !rx_fall)) &&
                         (to_cnt_reg == TO_LAST);

    // The count restarts at each entry to SEND or RECV: every leave from those
    // states (including SEND->RECV on the TX fall) clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_reg   <= '0;
            resp_err_reg <= 1'b0;
        end else begin
            if (((state_reg == SEND) && !tx_fall) || ((state_reg == RECV) && !rx_fall)) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end else begin
                to_cnt_reg <= '0;
            end

            if (timeout_hit) begin
                resp_err_reg <= 1'b1;
            end else if (state_reg == RESP) begin
                resp_err_reg <= 1'b0;
            end
        end
    end

    assign resp_err = resp_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    // Main sequencer. All engine-facing outputs are registered here; reset
    // drops chip select immediately, abandoning any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            write_reg        <= 1'b0;
            tx_done_prev_reg <= 1'b0;
            rx_done_prev_reg <= 1'b0;
            req_ready_reg    <= 1'b0;
            resp_valid_reg   <= 1'b0;
            resp_rdata_reg   <= '0;
            eng_csb_reg      <= 1'b1;
            eng_tx_reg       <= '0;
            eng_tx_start_reg <= 1'b0;
            eng_tx_busy_reg  <= 1'b1;
            eng_rx_busy_reg  <= 1'b1;
        end else begin
            tx_done_prev_reg <= eng_tx_done;
            rx_done_prev_reg <= eng_rx_done;
            resp_valid_reg   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        eng_tx_reg    <= frame_next;
                        write_reg     <= req_write;
                        eng_csb_reg   <= 1'b0;
                        cnt_reg       <= '0;
                        req_ready_reg <= 1'b0;
                        state_reg     <= SETUP;
                    end else begin
                        // Also arms ready on the first clock after reset.
                        req_ready_reg <= 1'b1;
                    end
                end

                SETUP: begin
                    if (cnt_reg == SETUP_LAST) begin
                        cnt_reg          <= '0;
                        eng_tx_busy_reg  <= 1'b0;
                        eng_tx_start_reg <= 1'b1;
                        state_reg        <= SEND;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                SEND: begin
                    if (tx_fall) begin
                        eng_tx_start_reg <= 1'b0;
                        eng_tx_busy_reg  <= 1'b1;
                        cnt_reg          <= '0;
                        if (write_reg) begin
                            state_reg <= HOLD;
                        end else begin
                            eng_rx_busy_reg <= 1'b0;
                            state_reg       <= RECV;
                        end
                    end else if (timeout_hit) begin
                        eng_tx_start_reg <= 1'b0;
                        eng_tx_busy_reg  <= 1'b1;
                        eng_rx_busy_reg  <= 1'b1;
                        eng_csb_reg      <= 1'b1;
                        resp_rdata_reg   <= '0;
                        resp_valid_reg   <= 1'b1;
                        state_reg        <= RESP;
                    end
                end

                RECV: begin
                    if (rx_fall) begin
                        resp_rdata_reg  <= eng_rx;
                        eng_rx_busy_reg <= 1'b1;
                        cnt_reg         <= '0;
                        state_reg       <= HOLD;
                    end else if (timeout_hit) begin
                        eng_tx_start_reg <= 1'b0;
                        eng_tx_busy_reg  <= 1'b1;
                        eng_rx_busy_reg  <= 1'b1;
                        eng_csb_reg      <= 1'b1;
                        resp_rdata_reg   <= '0;
                        resp_valid_reg   <= 1'b1;
                        state_reg        <= RESP;
                    end
                end

                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        eng_csb_reg    <= 1'b1;
                        resp_valid_reg <= 1'b1;
                        if (write_reg) begin
                            resp_rdata_reg <= '0;
                        end
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                RESP: begin
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_reg;
    assign resp_valid   = resp_valid_reg;
    assign resp_rdata   = resp_rdata_reg;
    assign eng_csb      = eng_csb_reg;
    assign eng_tx       = eng_tx_reg;
    assign eng_tx_start = eng_tx_start_reg;
    assign eng_tx_busy  = eng_tx_busy_reg;
    assign eng_rx_busy  = eng_rx_busy_reg;

endmodule

// File: tb/tb_serial_xact_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_xact_ctrl
//
// Directed bench for serial_xact_ctrl with a small behavioural serial-engine
// model. Each transaction prints one line. Build with +define+XACT_TIMEOUT_EN
// to exercise the watchdog; the default build checks the indefinite stall.
// ---------------------------------------------------------------------------
module tb_serial_xact_ctrl;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_write = 1'b0;
    logic [ADDR_W-1:0]  req_addr = '0;
    logic [DATA_W-1:0]  req_wdata = '0;
    logic               resp_valid;
    logic [DATA_W-1:0]  resp_rdata;
    logic               resp_err;
    logic               eng_csb;
    logic [FRAME_W-1:0] eng_tx;
    logic               eng_tx_start;
    logic               eng_tx_busy;
    logic               eng_rx_busy;
    logic               eng_tx_done = 1'b0;
    logic               eng_rx_done = 1'b0;
    logic [DATA_W-1:0]  eng_rx = 8'hEE;

    always #5 clk = ~clk;

    serial_xact_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .FRAME_W (FRAME_W),
        .CS_SETUP(4),
        .CS_HOLD (4),
        .TIMEOUT (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .eng_csb     (eng_csb),
        .eng_tx      (eng_tx),
        .eng_tx_start(eng_tx_start),
        .eng_tx_busy (eng_tx_busy),
        .eng_rx_busy (eng_rx_busy),
        .eng_tx_done (eng_tx_done),
        .eng_rx_done (eng_rx_done),
        .eng_rx      (eng_rx)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;
    int resp_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- engine model ----------------
    // TX: after start (unstalled) shift FRAME_W bits, pulse tx_done one cycle.
    // RX: after rx_busy drops, shift DATA_W bits, pulse rx_done; the RX word
    // becomes valid only when rx_done falls.
    logic              stall = 1'b0;
    logic [DATA_W-1:0] rx_word = '0;
    int tx_ph, tx_cnt, rx_ph, rx_cnt;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            tx_ph       = 0;
            tx_cnt      = 0;
            rx_ph       = 0;
            rx_cnt      = 0;
            eng_tx_done = 1'b0;
            eng_rx_done = 1'b0;
            eng_rx      = 8'hEE;
        end else begin
            case (tx_ph)
                0: if (eng_tx_start && !eng_tx_busy && !stall) begin tx_cnt = 0; tx_ph = 1; end
                1: begin
                    tx_cnt++;
                    if (tx_cnt == FRAME_W) begin eng_tx_done = 1'b1; tx_ph = 2; end
                end
                2: begin eng_tx_done = 1'b0; tx_ph = 3; end
                default: if (!eng_tx_start) tx_ph = 0;
            endcase
            case (rx_ph)
                0: if (!eng_rx_busy) begin rx_cnt = 0; rx_ph = 1; eng_rx = 8'hEE; end
                1: begin
                    rx_cnt++;
                    if (rx_cnt == DATA_W) begin eng_rx_done = 1'b1; rx_ph = 2; end
                end
                2: begin eng_rx_done = 1'b0; eng_rx = rx_word; rx_ph = 3; end
                default: if (eng_rx_busy) rx_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (resp_valid) resp_total++;
    end

    // ---------------- one full transaction ----------------
    // Called at a negedge; returns at the negedge after the response pulse.
    task automatic do_xact(input string name, input logic wr, input logic [6:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rword,
                           input logic [15:0] exp_frame, input logic [7:0] exp_rdata,
                           input bit keep_valid);
        int n;
        int setup_n, hold_n, ready_bad, rx_bad;
        bit started, serial_done, rx_seen_low;
        setup_n = 0; hold_n = 0; ready_bad = 0; rx_bad = 0;
        started = 0; serial_done = 0; rx_seen_low = 0;

        rx_word   = rword;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check({name, " ready"}, req_ready, 1);
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
        check({name, " frame"}, eng_tx, exp_frame);

        n = 0;
        while (!resp_valid && n < 400) begin
            if (req_ready) ready_bad++;
            if (!started) begin
                if (eng_tx_start) started = 1;
                else if (!eng_csb) setup_n++;
            end
            if (!eng_rx_busy) begin
                if (wr || eng_tx_start) rx_bad++;
                rx_seen_low = 1;
            end
            if (started && !serial_done) begin
                if (wr ? !eng_tx_start : (rx_seen_low && eng_rx_busy)) serial_done = 1;
            end
            if (serial_done && !eng_csb) hold_n++;
            @(negedge clk);
            n++;
        end
        check({name, " resp_valid"}, resp_valid, 1);
        check({name, " rdata"}, resp_rdata, exp_rdata);
        check({name, " err"}, resp_err, 0);
        check({name, " csb_at_resp"}, eng_csb, 1);
        check({name, " setup_cycles"}, setup_n, 4);
        check({name, " hold_cycles"}, hold_n, 4);
        check({name, " ready_during"}, ready_bad, 0);
        check({name, " rx_busy_misuse"}, rx_bad, 0);
        if (!wr) check({name, " rx_released"}, rx_seen_low, 1);
        @(negedge clk);
        check({name, " resp_one_cycle"}, resp_valid, 0);
        check({name, " ready_after"}, req_ready, 1);
        check({name, " rdata_held"}, resp_rdata, exp_rdata);
        $display("xact %s: %s addr=0x%0h frame=0x%0h rdata=0x%0h latency=%0d",
                 name, wr ? "WR" : "RD", addr, eng_tx, resp_rdata, n + 1);
    endtask

    initial begin
        int n;
        int snap;
        bit err_seen;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst csb", eng_csb, 1);
        check("rst tx", eng_tx, 0);
        check("rst start", eng_tx_start, 0);
        check("rst tx_busy", eng_tx_busy, 1);
        check("rst rx_busy", eng_rx_busy, 1);
        check("rst resp", {resp_valid, resp_err, resp_rdata}, 0);
        check("rst ready", req_ready, 0);
        rst = 1'b0;
        check("ready first cycle", req_ready, 0);
        @(negedge clk);
        check("ready armed", req_ready, 1);
        $display("xact reset: outputs at reset values");

        // ---- basic write / read ----
        do_xact("wr15", 1'b1, 7'h15, 8'hA5, 8'h00, 16'h95A5, 8'h00, 1'b0);
        do_xact("rd03", 1'b0, 7'h03, 8'hFF, 8'h3C, 16'h0300, 8'h3C, 1'b0);

        // ---- back-to-back with req_valid held high ----
        do_xact("b2b_wr7f", 1'b1, 7'h7F, 8'h5A, 8'h00, 16'hFF5A, 8'h00, 1'b1);
        do_xact("b2b_rd40", 1'b0, 7'h40, 8'h00, 8'hC3, 16'h4000, 8'hC3, 1'b0);

        // ---- reset in the middle of SEND ----
        rx_word   = 8'h77;
        req_write = 1'b0;
        req_addr  = 7'h2A;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!eng_tx_start && n < 50) begin @(negedge clk); n++; end
        check("midrst in_send", eng_tx_start, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst csb_async", eng_csb, 1);
        check("midrst start_async", eng_tx_start, 0);
        snap = resp_total;
        @(negedge clk);
        rst = 1'b0;
        check("midrst ready_low", req_ready, 0);
        repeat (20) @(negedge clk);
        check("midrst no_resp", resp_total - snap, 0);
        $display("xact midrst: aborted read addr=0x2a, csb=%0d", eng_csb);
        do_xact("rd2a", 1'b0, 7'h2A, 8'h00, 8'h99, 16'h2A00, 8'h99, 1'b0);

        // ---- engine stall ----
        stall     = 1'b1;
        req_write = 1'b0;
        req_addr  = 7'h11;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!eng_tx_start && n < 50) begin @(negedge clk); n++; end
        check("stall in_send", eng_tx_start, 1);
`ifdef XACT_TIMEOUT_EN
        // Current sample is cycle 1 of SEND.
        n = 1;
        while (!resp_valid && n < 200) begin @(negedge clk); n++; end
        check("timeout cycle", n, 51);
        check("timeout resp_valid", resp_valid, 1);
        check("timeout err", resp_err, 1);
        check("timeout rdata", resp_rdata, 0);
        check("timeout csb", eng_csb, 1);
        check("timeout engine", {eng_tx_start, eng_tx_busy, eng_rx_busy}, 3'b011);
        @(negedge clk);
        check("timeout pulse", {resp_valid, resp_err, req_ready}, 3'b001);
        $display("xact timeout: RD addr=0x11 err=1 after %0d SEND cycles", n - 1);
        stall = 1'b0;
`else
        snap     = resp_total;
        err_seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (resp_err) err_seen = 1;
        end
        check("stall no_resp", resp_total - snap, 0);
        check("stall err_zero", err_seen, 0);
        check("stall still_selected", {eng_csb, eng_tx_start}, 2'b01);
        $display("xact stall: RD addr=0x11 still waiting after 2000 cycles");
        stall = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_xact("rd11", 1'b0, 7'h11, 8'h00, 8'h5E, 16'h1100, 8'h5E, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
